// File: rtl/pipereg_skid.sv
// Two-entry (main + skid) valid/ready pipeline stage register with flush, global hold
// and a saturating bubble-cycle counter; outputs always present the main entry.
module pipereg_skid #(
    parameter int unsigned     DATA_W   = 256,
    parameter int unsigned     PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000),
    parameter int unsigned     CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bubble,
    input  logic              flush,
    input  logic              hold,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_ILLEGAL = 2'b01,
        ST_ONE     = 2'b10,
        ST_FULL    = 2'b11
    } occ_state_e;

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    occ_state_e cur_st;
    logic       in_fire;
    logic       out_fire;

    assign cur_st     = occ_state_e'({main_v_q, skid_v_q});
    assign out_valid  = main_v_q & ~hold;
    assign in_ready   = ~skid_v_q & ~hold & ~flush;
    assign out_bubble = ~out_valid;
    assign out_pc     = main_pc_q;
    assign out_data   = main_data_q;
    assign occupancy  = {1'b0, main_v_q} + {1'b0, skid_v_q};
    assign bubble_cnt = bubble_cnt_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_pc_d   = main_pc_q;
        skid_pc_d   = skid_pc_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Payload registers keep their contents; only the entries are invalidated.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!hold) begin
            case (cur_st)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_v_d    = 1'b1;
                        main_pc_d   = in_pc;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_pc_d   = in_pc;
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        skid_v_d    = 1'b1;
                        skid_pc_d   = in_pc;
                        skid_data_d = in_data;
                    end else if (out_fire) begin
                        main_v_d = 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        skid_v_d    = 1'b0;
                        main_pc_d   = skid_pc_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (out_bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: the payload registers are reset too, so out_pc/out_data show defined values after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_v_q     <= 1'b0;
            skid_v_q     <= 1'b0;
            main_pc_q    <= RESET_PC;
            skid_pc_q    <= '0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            main_v_q     <= main_v_d;
            skid_v_q     <= skid_v_d;
            main_pc_q    <= main_pc_d;
            skid_pc_q    <= skid_pc_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipereg_skid.sv
// Directed bench for pipereg_skid: a queue-based FIFO model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_pipereg_skid;

    localparam int unsigned DATA_W = 256;
    localparam int unsigned PC_W   = 64;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, in_ready2;
    logic [PC_W-1:0]   in_pc;
    logic [DATA_W-1:0] in_data;
    logic              out_valid, out_valid2;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc, out_pc2;
    logic [DATA_W-1:0] out_data, out_data2;
    logic              out_bubble, out_bubble2;
    logic              flush, hold;
    logic [1:0]        occupancy, occupancy2;
    logic [31:0]       bubble_cnt;
    logic [1:0]        bubble_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipereg_skid dut (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
        .out_bubble(out_bubble), .flush(flush), .hold(hold),
        .occupancy(occupancy), .bubble_cnt(bubble_cnt)
    );

    pipereg_skid #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2), .in_pc(in_pc), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_pc(out_pc2), .out_data(out_data2),
        .out_bubble(out_bubble2), .flush(flush), .hold(hold),
        .occupancy(occupancy2), .bubble_cnt(bubble_cnt2)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] mkdata(input logic [63:0] pc);
        return {pc ^ 64'hDEAD_BEEF_0000_0000, ~pc, pc + 64'd1, {pc[31:0], pc[63:32]}};
    endfunction

    // Model: a FIFO of at most two entries; the presented slot is the head, or the last head once empty.
    ent_t        mq[$];
    ent_t        mshow = '{pc: RST_PC, data: '0};
    logic [31:0] m_cnt = '0;
    logic [1:0]  m_cnt2 = '0;
    logic [63:0] delivered[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mshow  = '{pc: RST_PC, data: '0};
            m_cnt  = '0;
            m_cnt2 = '0;
        end else begin
            bit m_ov, m_ir;
            m_ov = (mq.size() > 0) && !hold;
            m_ir = (mq.size() < 2) && !hold && !flush;
            if (!m_ov) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 1;
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (m_ov && out_ready) void'(mq.pop_front());
                if (in_valid && m_ir) mq.push_back('{pc: in_pc, data: in_data});
            end
            if (mq.size() > 0) mshow = mq[0];
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            bit m_ov;
            m_ov = (mq.size() > 0) && !hold;
            check("cmp_out_valid", out_valid, m_ov);
            check("cmp_out_bubble", out_bubble, !m_ov);
            check("cmp_in_ready", in_ready, (mq.size() < 2) && !hold && !flush);
            check("cmp_occupancy", occupancy, 256'(mq.size()));
            check("cmp_out_pc", out_pc, mshow.pc);
            check("cmp_out_data", out_data, mshow.data);
            check("cmp_bubble_cnt", bubble_cnt, m_cnt);
            check("cmp_bubble_cnt2", bubble_cnt2, m_cnt2);
            if (out_valid && out_ready) delivered.push_back(out_pc);
        end
    end

    task automatic drive(input logic v, input logic [63:0] pc, input logic ordy,
                         input logic h, input logic f);
        in_valid  = v;
        in_pc     = pc;
        in_data   = mkdata(pc);
        out_ready = ordy;
        hold      = h;
        flush     = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp_del[6];
        exp_del = '{64'h100, 64'h104, 64'h108, 64'h200, 64'h204, 64'h400};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bubble", out_bubble, 1);
        check("rst_out_pc", out_pc, 64'h8000_0000);
        check("rst_out_data", out_data, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_bubble_cnt", bubble_cnt, 0);
        tick(); check("bcnt_1", bubble_cnt, 1);
        tick(); check("bcnt_2", bubble_cnt, 2);
        tick(); check("bcnt_3", bubble_cnt, 3);
        tick(); check("bcnt_4", bubble_cnt, 4);
        check("bcnt2_sat", bubble_cnt2, 3);

        // Streaming
        drive(1, 64'h100, 1, 0, 0); tick();
        check("str_pc0", out_pc, 64'h100); check("str_occ0", occupancy, 1);
        check("str_rdy0", in_ready, 1);    check("str_val0", out_valid, 1);
        drive(1, 64'h104, 1, 0, 0); tick();
        check("str_pc1", out_pc, 64'h104); check("str_occ1", occupancy, 1);
        drive(1, 64'h108, 1, 0, 0); tick();
        check("str_pc2", out_pc, 64'h108); check("str_occ2", occupancy, 1);
        check("str_data2", out_data, mkdata(64'h108));
        drive(0, 0, 1, 0, 0); tick();
        check("str_drain_occ", occupancy, 0); check("str_drain_pc", out_pc, 64'h108);

        // Backpressure
        drive(1, 64'h200, 0, 0, 0); tick();
        drive(1, 64'h204, 0, 0, 0); tick();
        check("bp_occ_full", occupancy, 2); check("bp_in_ready", in_ready, 0);
        check("bp_pc_head", out_pc, 64'h200);
        drive(0, 0, 1, 0, 0); tick();
        check("bp_pc_second", out_pc, 64'h204); check("bp_occ_one", occupancy, 1);
        tick();
        check("bp_occ_empty", occupancy, 0);

        // Flush while FULL with a new payload offered
        drive(1, 64'h300, 0, 0, 0); tick();
        drive(1, 64'h304, 0, 0, 0); tick();
        check("fl_occ_full", occupancy, 2);
        drive(1, 64'h308, 0, 0, 1);
        check("fl_in_ready", in_ready, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        check("fl_occ", occupancy, 0); check("fl_bubble", out_bubble, 1);
        check("fl_pc_kept", out_pc, 64'h300);
        tick();
        check("fl_no_capture", occupancy, 0); check("fl_pc_still", out_pc, 64'h300);

        // Hold for three cycles
        drive(1, 64'h400, 0, 0, 0); tick();
        drive(0, 0, 1, 1, 0);
        check("hd_out_valid", out_valid, 0); check("hd_in_ready", in_ready, 0);
        check("hd_bubble", out_bubble, 1);   check("hd_pc", out_pc, 64'h400);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hd_occ", occupancy, 1);
            check("hd_val", out_valid, 0);
            check("hd_pc_cyc", out_pc, 64'h400);
        end
        drive(0, 0, 1, 0, 0);
        check("hd_release_valid", out_valid, 1);
        tick(); check("hd_once_occ", occupancy, 0);
        tick(); check("hd_once_val", out_valid, 0);

        check("del_count", delivered.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check("del_order", (i < delivered.size()) ? delivered[i] : 64'hX, exp_del[i]);
        end

        // Flush with a concurrent consumption
        drive(1, 64'h310, 0, 0, 0); tick();
        drive(1, 64'h314, 1, 0, 1);
        check("flc_out_valid", out_valid, 1); check("flc_in_ready", in_ready, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        check("flc_occ", occupancy, 0); check("flc_pc", out_pc, 64'h310);

        // Asynchronous reset pulse while FULL
        drive(1, 64'h500, 0, 0, 0); tick();
        drive(1, 64'h504, 0, 0, 0); tick();
        check("ar_occ_full", occupancy, 2);
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0); check("ar_occ", occupancy, 0);
        check("ar_in_ready", in_ready, 1);   check("ar_pc", out_pc, 64'h8000_0000);
        check("ar_data", out_data, 0);       check("ar_bcnt", bubble_cnt, 0);
        check("ar_bcnt2", bubble_cnt2, 0);
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("ar_bcnt_6", bubble_cnt, 6);
        check("ar_bcnt2_sat", bubble_cnt2, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipereg_skid.md
Name: pipereg_skid

Overview:
- Parametrised successor to the fixed MEM/WB-style stage register. It carries an opaque payload plus PC between two pipeline stages using a valid/ready handshake.
- A second (skid) entry lets the upstream stage keep running for one cycle after the downstream stage stalls, so in_ready does not depend combinationally on out_ready.
- Adds an explicit flush input, a global hold (freeze) input, and a saturating bubble-cycle performance counter.
- Any stage boundary in the pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB) can instantiate it.

Parameters:
- DATA_W, 256, payload width in bits (result/ctl/dst/csr fields packed by the instantiating stage).
- PC_W, 64, PC width.
- RESET_PC, 64'h8000_0000, PC value presented on out_pc after reset.
- CNT_W, 32, width of the bubble-cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  block can accept a payload this cycle.
- in_pc  in  PC_W  upstream PC.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  payload presented downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_pc  out  PC_W  presented PC.
- out_data  out  DATA_W  presented payload.
- out_bubble  out  1  equals ~out_valid; marks the presented slot as a bubble.
- flush  in  1  discard all held entries (branch mispredict / trap).
- hold  in  1  global freeze (e.g. Iwait|Dwait).
- occupancy  out  2  number of valid entries: 0, 1 or 2.
- bubble_cnt  out  CNT_W  saturating count of cycles with out_bubble=1.

Behaviour:
- Storage: main entry (main_v, main_pc, main_data) and skid entry (skid_v, skid_pc, skid_data).
- The outputs always present the main entry: out_pc=main_pc, out_data=main_data.
- Combinational outputs:
  - out_valid = main_v & ~hold
  - in_ready = ~skid_v & ~hold & ~flush
  - occupancy = main_v + skid_v
- Fire conditions:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Reset (reset=0, asynchronous):
  - main_v=0, skid_v=0, main_pc=RESET_PC, main_data=0, skid_pc=0, skid_data=0, bubble_cnt=0.
  - Therefore out_valid=0, out_bubble=1 and in_ready=1 once reset releases (hold=0, flush=0).
- States are encoded by {main_v, skid_v}. State (0,1) is illegal and unreachable.
- EMPTY (0,0):
  - in_fire -> ONE; main <= in.
- ONE (1,0):
  - in_fire & out_fire -> ONE; main <= in.
  - in_fire & ~out_fire -> FULL; skid <= in.
  - ~in_fire & out_fire -> EMPTY.
  - Otherwise, no change.
- FULL (1,1):
  - in_ready=0.
  - out_fire -> ONE; main <= skid; skid_v <= 0.
  - Otherwise, no change.
- Latency: a payload accepted at edge N is presented at edge N (visible in cycle N+1) when the block was EMPTY or draining. Ordering is strictly FIFO.
- Priority: reset > flush > hold > normal transitions.
- flush=1:
  - Next state is EMPTY regardless of in_valid or out_ready.
  - Data registers keep their contents; only the valid bits clear.
  - An out_fire in the same cycle is still a legal consumption; the consumer owns that result.
- hold=1 (flush=0):
  - No state or data change.
  - out_valid=0 and out_bubble=1, but out_pc/out_data keep showing the main entry (last data marked as bubble).
  - in_ready=0.
- Payload registers load only on the transitions listed above. Values on in_* with no in_fire are never captured.
- bubble_cnt:
  - Increments by 1 every cycle with out_bubble=1 and reset deasserted.
  - Saturates at 2^CNT_W-1; does not wrap.
  - Cleared only by reset; flush does not clear it.
- Reset asserted mid-transfer drops both entries immediately (asynchronous). No partial state survives.

Test Plan:
- Reset release with in_valid=0 -> out_valid=0, out_bubble=1, out_pc=0x8000_0000, occupancy=0, in_ready=1; bubble_cnt counts 1,2,3 on the following cycles.
- Streaming: out_ready=1, in_valid=1, pc 0x100, 0x104, 0x108 on consecutive cycles -> out_pc 0x100, 0x104, 0x108 on the next cycles, occupancy stays 1, in_ready stays 1.
- Backpressure: out_ready=0 while sending 0x200, 0x204 -> occupancy=2 and in_ready=0. Then out_ready=1 -> outputs 0x200 then 0x204, in order, with no loss and no duplicate.
- Flush while FULL (0x300, 0x304) with in_valid=1 carrying 0x308 -> next cycle occupancy=0, out_bubble=1, 0x308 not captured; bubble_cnt increments.
- hold=1 for 3 cycles while main holds 0x400 -> out_valid=0, out_pc=0x400, occupancy unchanged, in_ready=0. After release, 0x400 is delivered exactly once.
- Async reset pulse mid-cycle while FULL -> outputs return to reset values before the next clock edge. CNT_W=2 run -> bubble_cnt saturates at 3.
